// File: rtl/addsub_seq_cla.sv
// Multi-cycle two's-complement adder/subtractor: one CHUNK-bit carry-lookahead
// slice per clock, LSB slice first, carry held in a register between slices.

module addsub_seq_cla_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] sum_o,
    output logic         c_o,
    output logic         c_msb_o
);
    logic [W-1:0] g, p;
    logic [W:0]   c;
    logic         pp, ci;

    // Each carry is a flat sum of generate terms gated by the propagate run
    // above them, so no carry depends on another computed carry.
    always_comb begin
        g    = a_i & b_i;
        p    = a_i ^ b_i;
        c    = '0;
        pp   = 1'b1;
        ci   = 1'b0;
        c[0] = c_i;
        for (int i = 1; i <= W; i++) begin
            pp = 1'b1;
            ci = 1'b0;
            for (int j = i - 1; j >= 0; j--) begin
                ci = ci | (g[j] & pp);
                pp = pp & p[j];
            end
            c[i] = ci | (c_i & pp);
        end
    end

    assign sum_o   = p ^ c[W-1:0];
    assign c_o     = c[W];
    assign c_msb_o = c[W-1];
endmodule

module addsub_seq_cla #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;

    logic [CHUNK-1:0] sl_a, sl_b, sl_sum;
    logic             sl_co, sl_cmsb;

    assign sl_a = a_q[int'(cnt_q)*CHUNK +: CHUNK];
    assign sl_b = b_q[int'(cnt_q)*CHUNK +: CHUNK];

    addsub_seq_cla_slice #(.W(CHUNK)) u_slice (
        .a_i     (sl_a),
        .b_i     (sl_b),
        .c_i     (carry_q),
        .sum_o   (sl_sum),
        .c_o     (sl_co),
        .c_msb_o (sl_cmsb)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // b is stored pre-inverted; the +1 of subtraction is slice 0's carry-in
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                res_d[int'(cnt_q)*CHUNK +: CHUNK] = sl_sum;
                carry_d = sl_co;
                if (cnt_q == CW'(N - 1)) begin
                    cout_d  = sl_co;
                    ovf_d   = sl_cmsb ^ sl_co;
                    zero_d  = (res_d == '0);
                    neg_d   = res_d[WIDTH-1];
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = res_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
endmodule

// File: tb/tb_addsub_seq_cla.sv
// Scoreboard bench: two instances (16/4 and 8/8), random and directed operations
// checked against an arithmetic reference model.

module tb_addsub_seq_cla;
    typedef struct {
        logic [15:0] res;
        logic        c, v, z, n;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        iv16, ir16, sub16, ov16, or16, c16, v16, z16, n16;
    logic [15:0] a16, b16, res16;
    logic        iv8, ir8, sub8, ov8, or8, c8, v8, z8, n8;
    logic [7:0]  a8, b8, res8;

    addsub_seq_cla #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .sub(sub16), .out_valid(ov16), .out_ready(or16), .result(res16), .cout(c16),
        .ovf(v16), .zero(z16), .neg(n16));

    addsub_seq_cla #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .sub(sub8), .out_valid(ov8), .out_ready(or8), .result(res8), .cout(c8),
        .ovf(v8), .zero(z8), .neg(n8));

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   rand_or = 0;
    bit   pv16 = 0, pv8 = 0;
    exp_t q16[$];
    exp_t q8[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(logic [15:0] r, logic c, logic v, logic z, logic n);
        exp_t e;
        e.res = r; e.c = c; e.v = v; e.z = z; e.n = n; e.acc = 0;
        return e;
    endfunction

    // Reference: plain unsigned/signed integer arithmetic on w-bit operands.
    function automatic exp_t model(int w, longint a, longint b, bit s);
        exp_t   e;
        longint m, sa, sb, t, lim;
        m   = (longint'(1) << w) - 1;
        lim = longint'(1) << (w - 1);
        a   = a & m;
        b   = b & m;
        sa  = (a >= lim) ? a - (longint'(1) << w) : a;
        sb  = (b >= lim) ? b - (longint'(1) << w) : b;
        t   = s ? sa - sb : sa + sb;
        e.res = 16'((s ? a - b : a + b) & m);
        e.c   = s ? (a >= b) : (((a + b) >> w) != 0);
        e.v   = (t >= lim) || (t < -lim);
        e.z   = (e.res == 16'h0);
        e.n   = e.res[w-1];
        e.acc = 0;
        return e;
    endfunction

    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic s, input exp_t e);
        int n = 0;
        @(negedge clk);
        while (!ir16 && n < 200) begin @(negedge clk); n++; end
        if (!ir16) begin
            checks++; errors++;
            $display("FAIL issue16_timeout in_ready=%b required 1", ir16);
            return;
        end
        a16 = a; b16 = b; sub16 = s; iv16 = 1'b1;
        e.acc = cyc + 1;
        q16.push_back(e);
        @(posedge clk); #1;
        iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom);
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s, input exp_t e);
        int n = 0;
        @(negedge clk);
        while (!ir8 && n < 200) begin @(negedge clk); n++; end
        if (!ir8) begin
            checks++; errors++;
            $display("FAIL issue8_timeout in_ready=%b required 1", ir8);
            return;
        end
        a8 = a; b8 = b; sub8 = s; iv8 = 1'b1;
        e.acc = cyc + 1;
        q8.push_back(e);
        @(posedge clk); #1;
        iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((q16.size() != 0 || q8.size() != 0) && n < 500) begin @(negedge clk); n++; end
        checks++;
        if (q16.size() != 0 || q8.size() != 0) begin
            errors++;
            $display("FAIL drain pending16=%0d pending8=%0d required 0", q16.size(), q8.size());
        end
    endtask

    // Monitors: latency on out_valid rise, full result/flags on each handshake.
    always @(negedge clk) begin
        exp_t e;
        if (ov16 && !pv16 && q16.size() != 0) begin
            checks++;
            if (cyc - q16[0].acc != 4) begin
                errors++;
                $display("FAIL lat16 got=%0d required=4", cyc - q16[0].acc);
            end
        end
        pv16 = ov16;
        if (ov16 && or16) begin
            checks++;
            if (q16.size() == 0) begin
                errors++;
                $display("FAIL spurious16 out_valid with nothing outstanding res=%h", res16);
            end else begin
                e = q16.pop_front();
                if ({res16, c16, v16, z16, n16} !== {e.res, e.c, e.v, e.z, e.n}) begin
                    errors++;
                    $display("FAIL res16 got=%h c%b v%b z%b n%b required=%h c%b v%b z%b n%b",
                             res16, c16, v16, z16, n16, e.res, e.c, e.v, e.z, e.n);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (ov8 && !pv8 && q8.size() != 0) begin
            checks++;
            if (cyc - q8[0].acc != 1) begin
                errors++;
                $display("FAIL lat8 got=%0d required=1", cyc - q8[0].acc);
            end
        end
        pv8 = ov8;
        if (ov8 && or8) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL spurious8 out_valid with nothing outstanding res=%h", res8);
            end else begin
                e = q8.pop_front();
                if ({res8, c8, v8, z8, n8} !== {e.res[7:0], e.c, e.v, e.z, e.n}) begin
                    errors++;
                    $display("FAIL res8 got=%h c%b v%b z%b n%b required=%h c%b v%b z%b n%b",
                             res8, c8, v8, z8, n8, e.res[7:0], e.c, e.v, e.z, e.n);
                end
            end
        end
    end

    // Random consumer backpressure when enabled; changes away from both edges.
    initial begin
        forever begin
            @(posedge clk); #2;
            if (rand_or) begin
                or16 = ($urandom_range(0, 2) != 0);
                or8  = ($urandom_range(0, 2) != 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] ra, rb;
        logic [7:0]  ra8, rb8;
        logic        rs;
        logic [19:0] snap;
        int          n;
        bit          bad;

        rst_n = 1'b0;
        iv16 = 0; a16 = 0; b16 = 0; sub16 = 0; or16 = 1;
        iv8 = 0;  a8 = 0;  b8 = 0;  sub8 = 0;  or8 = 1;
        #17;
        checks++;
        if ({ov16, res16, c16, v16, z16, n16, ir16} !== {1'b0, 16'h0, 4'h0, 1'b1} ||
            {ov8, res8, c8, v8, z8, n8, ir8} !== {1'b0, 8'h0, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state ov16=%b res16=%h ir16=%b ov8=%b res8=%h ir8=%b required 0/0/1",
                     ov16, res16, ir16, ov8, res8, ir8);
        end
        @(negedge clk); rst_n = 1'b1;

        // Directed arithmetic cases
        issue16(16'h1234, 16'h0FCC, 1'b0, mk(16'h2200, 0, 0, 0, 0));
        issue16(16'h0005, 16'h0007, 1'b1, mk(16'hFFFE, 0, 0, 0, 1));
        issue16(16'h8000, 16'h0001, 1'b1, mk(16'h7FFF, 1, 1, 0, 0));
        issue16(16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1, 0, 1, 0));
        issue16(16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 0, 1, 0, 1));
        issue16(16'h4321, 16'h0000, 1'b1, mk(16'h4321, 1, 0, 0, 0));
        drain();

        // Backpressure: held DONE ignores new operands and keeps outputs stable
        @(posedge clk); #2; or16 = 1'b0;
        issue16(16'h00FF, 16'h0F01, 1'b1, model(16, 16'h00FF, 16'h0F01, 1'b1));
        n = 0;
        while (!ov16 && n < 50) begin @(negedge clk); n++; end
        snap = {res16, c16, v16, z16, n16};
        repeat (6) begin
            @(negedge clk);
            checks++;
            if ({res16, c16, v16, z16, n16} !== snap || !ov16 || ir16) begin
                errors++;
                $display("FAIL hold16 got=%h ov=%b ir=%b required=%h ov=1 ir=0",
                         {res16, c16, v16, z16, n16}, ov16, ir16, snap);
            end
            iv16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom);
        end
        iv16 = 1'b0;
        @(posedge clk); #2; or16 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ov16 || !ir16) begin
            errors++;
            $display("FAIL release16 ov=%b ir=%b required ov=0 ir=1", ov16, ir16);
        end
        issue16(16'h1111, 16'h2222, 1'b0, mk(16'h3333, 0, 0, 0, 0));

        // Random operations with random consumer stalls
        rand_or = 1;
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
            if (i % 8 == 0) rb = 16'h0000;
            if (i % 8 == 1) rb = ra;
            issue16(ra, rb, rs, model(16, ra, rb, rs));
        end
        drain();
        rand_or = 0;
        @(posedge clk); #2; or16 = 1'b1; or8 = 1'b1;

        // Asynchronous reset mid-operation discards the operation
        issue16(16'h1234, 16'h1111, 1'b0, mk(16'h2345, 0, 0, 0, 0));
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        void'(q16.pop_back());
        checks++;
        if ({ov16, res16, c16, v16, z16, n16, ir16} !== {1'b0, 16'h0, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset16 ov=%b res=%h c%b v%b z%b n%b ir=%b required all 0, ir=1",
                     ov16, res16, c16, v16, z16, n16, ir16);
        end
        @(negedge clk); rst_n = 1'b1;
        bad = 0;
        repeat (8) begin @(negedge clk); if (ov16) bad = 1; end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL no_valid_after_reset out_valid=1 required 0");
        end
        issue16(16'h0003, 16'h0003, 1'b1, mk(16'h0000, 1, 0, 1, 0));
        drain();

        // Single-slice instance
        issue8(8'h80, 8'h80, 1'b0, mk(16'h0000, 1, 1, 1, 0));
        issue8(8'h7F, 8'h01, 1'b0, mk(16'h0080, 0, 1, 0, 1));
        issue8(8'h01, 8'h02, 1'b1, mk(16'h00FF, 0, 0, 0, 1));
        rand_or = 1;
        for (int i = 0; i < 20; i++) begin
            ra8 = 8'($urandom); rb8 = 8'($urandom); rs = 1'($urandom);
            issue8(ra8, rb8, rs, model(8, ra8, rb8, rs));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
